// File: rtl/car_traffic_gen_pkg.sv
// rtl/car_traffic_gen_pkg.sv - shared widths, grid defaults and lane period helper for the car traffic generator
// Contents:
//   COORD_W, NUM_CARS, GRID_W_DEF, GRID_H_DEF  geometry shared with the collision checker and renderer
//   PERIOD_W                                   width of a lane period and of a lane counter
//   eff_period()                               level-scaled lane period, never below 1
package car_traffic_gen_pkg;

  localparam int COORD_W    = 6;
  localparam int NUM_CARS   = 5;
  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;
  localparam int PERIOD_W   = 8;

  // Each speed level halves the period. Short lanes would reach zero at high levels,
  // which would stall the car, so the result is held at one tick per step.
  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] base,
                                                     input logic [1:0]          level);
    logic [PERIOD_W-1:0] p;
    p = base >> level;
    return (p == '0) ? PERIOD_W'(1) : p;
  endfunction

endpackage

// File: rtl/car_traffic_gen_lane.sv
// rtl/car_traffic_gen_lane.sv - one road lane: per-lane step counter and wrapping X position of its car
// Ports:
//   i_Clk, i_Rst_L  clock, asynchronous active-low reset
//   i_Tick          base movement tick from the top-level divider
//   i_Restart       synchronous reload of the start position and counter
//   i_Level         speed level 0..3
//   o_X, o_Y        car coordinates
//   o_Step          high for one cycle when o_X has just changed
module car_lane
  import car_traffic_gen_pkg::*;
#(
  parameter logic [COORD_W-1:0]  X0     = '0,
  parameter logic [COORD_W-1:0]  Y      = '0,
  parameter logic                DIR    = 1'b1,
  parameter logic [PERIOD_W-1:0] PERIOD = PERIOD_W'(1),
  parameter int                  GRID_W = GRID_W_DEF
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Tick,
  input  logic               i_Restart,
  input  logic [1:0]         i_Level,
  output logic [COORD_W-1:0] o_X,
  output logic [COORD_W-1:0] o_Y,
  output logic               o_Step
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);

  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_period;
  logic [COORD_W-1:0]  w_next_x;

  // Level is read combinationally at each tick, so a level change lands on the next tick.
  assign w_period = eff_period(PERIOD, i_Level);

  always_comb begin
    w_next_x = o_X;
    if (DIR) begin
      w_next_x = (o_X == X_MAX) ? '0 : o_X + COORD_W'(1);
    end else begin
      w_next_x = (o_X == '0) ? X_MAX : o_X - COORD_W'(1);
    end
  end

  // The >= compare catches a counter left above a period that just shrank with a level increase.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_X    <= X0;
      r_cnt  <= '0;
      o_Step <= 1'b0;
    end else if (i_Restart) begin
      o_X    <= X0;
      r_cnt  <= '0;
      o_Step <= 1'b0;
    end else begin
      o_Step <= 1'b0;
      if (i_Tick) begin
        if (r_cnt >= w_period - PERIOD_W'(1)) begin
          r_cnt  <= '0;
          o_X    <= w_next_x;
          o_Step <= 1'b1;
        end else begin
          r_cnt <= r_cnt + PERIOD_W'(1);
        end
      end
    end
  end

  assign o_Y = Y;

endmodule

// File: rtl/car_traffic_gen.sv
// rtl/car_traffic_gen.sv - five-lane car position generator feeding collision and render
// Ports:
//   i_Clk, i_Rst_L            clock, asynchronous active-low reset
//   i_Enable, i_Freeze        traffic runs only while enabled and not frozen
//   i_Restart                 one-cycle pulse reloading start positions and clearing counters
//   i_Level                   speed level 0..3
//   o_Car_X_1..5, o_Car_Y_1..5  car grid coordinates
//   o_Move_Strobe             one-cycle pulse in the cycle any car X changed
module car_traffic_gen
  import car_traffic_gen_pkg::*;
#(
  parameter int                           TICK_DIV    = 25000,
  parameter int                           GRID_W      = GRID_W_DEF,
  parameter logic [NUM_CARS*COORD_W-1:0]  LANE_Y      = {6'd5, 6'd4, 6'd3, 6'd2, 6'd1},
  parameter logic [NUM_CARS*COORD_W-1:0]  LANE_X0     = {6'd30, 6'd8, 6'd20, 6'd0, 6'd12},
  parameter logic [NUM_CARS-1:0]          LANE_DIR    = 5'b01010,
  parameter logic [NUM_CARS*PERIOD_W-1:0] LANE_PERIOD = {8'd6, 8'd10, 8'd4, 8'd8, 8'd12}
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Enable,
  input  logic               i_Freeze,
  input  logic               i_Restart,
  input  logic [1:0]         i_Level,
  output logic [COORD_W-1:0] o_Car_X_1,
  output logic [COORD_W-1:0] o_Car_X_2,
  output logic [COORD_W-1:0] o_Car_X_3,
  output logic [COORD_W-1:0] o_Car_X_4,
  output logic [COORD_W-1:0] o_Car_X_5,
  output logic [COORD_W-1:0] o_Car_Y_1,
  output logic [COORD_W-1:0] o_Car_Y_2,
  output logic [COORD_W-1:0] o_Car_Y_3,
  output logic [COORD_W-1:0] o_Car_Y_4,
  output logic [COORD_W-1:0] o_Car_Y_5,
  output logic               o_Move_Strobe
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [TICK_W-1:0]   r_tick_cnt;
  logic                w_run;
  logic                w_tick;
  logic [COORD_W-1:0]  w_x [NUM_CARS];
  logic [COORD_W-1:0]  w_y [NUM_CARS];
  logic [NUM_CARS-1:0] w_step;

  assign w_run  = i_Enable & ~i_Freeze;
  assign w_tick = w_run & (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tick_cnt <= '0;
    end else if (i_Restart) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else if (w_run) begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  for (genvar n = 0; n < NUM_CARS; n++) begin : g_lane
    car_lane #(
      .X0    (LANE_X0[COORD_W*n +: COORD_W]),
      .Y     (LANE_Y[COORD_W*n +: COORD_W]),
      .DIR   (LANE_DIR[n]),
      .PERIOD(LANE_PERIOD[PERIOD_W*n +: PERIOD_W]),
      .GRID_W(GRID_W)
    ) u_lane (
      .i_Clk    (i_Clk),
      .i_Rst_L  (i_Rst_L),
      .i_Tick   (w_tick),
      .i_Restart(i_Restart),
      .i_Level  (i_Level),
      .o_X      (w_x[n]),
      .o_Y      (w_y[n]),
      .o_Step   (w_step[n])
    );
  end

  // Steps of all lanes land on the same cycle, so one OR gives a single pulse.
  assign o_Move_Strobe = |w_step;

  assign o_Car_X_1 = w_x[0];
  assign o_Car_X_2 = w_x[1];
  assign o_Car_X_3 = w_x[2];
  assign o_Car_X_4 = w_x[3];
  assign o_Car_X_5 = w_x[4];
  assign o_Car_Y_1 = w_y[0];
  assign o_Car_Y_2 = w_y[1];
  assign o_Car_Y_3 = w_y[2];
  assign o_Car_Y_4 = w_y[3];
  assign o_Car_Y_5 = w_y[4];

endmodule

// File: tb/tb_car_traffic_gen.sv
// tb/tb_car_traffic_gen.sv - scoreboard bench for car_traffic_gen with directed scenario checks
module tb_car_traffic_gen;

  localparam int TICK_DIV = 4;
  localparam int GRID_W   = 40;
  localparam logic [29:0] X0_PACK = {6'd30, 6'd8, 6'd20, 6'd0, 6'd12};
  localparam logic [29:0] Y_PACK  = {6'd5, 6'd4, 6'd3, 6'd2, 6'd1};

  int X0     [5] = '{12, 0, 20, 8, 30};
  int DIR    [5] = '{0, 1, 0, 1, 0};
  int PERIOD [5] = '{12, 8, 4, 10, 6};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       frz;
  logic       restart;
  logic [1:0] lvl;
  logic [5:0] x1, x2, x3, x4, x5;
  logic [5:0] y1, y2, y3, y4, y5;
  logic       strobe;

  always #5 clk = ~clk;

  car_traffic_gen #(
    .TICK_DIV(TICK_DIV),
    .GRID_W  (GRID_W)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Enable     (en),
    .i_Freeze     (frz),
    .i_Restart    (restart),
    .i_Level      (lvl),
    .o_Car_X_1    (x1),
    .o_Car_X_2    (x2),
    .o_Car_X_3    (x3),
    .o_Car_X_4    (x4),
    .o_Car_X_5    (x5),
    .o_Car_Y_1    (y1),
    .o_Car_Y_2    (y2),
    .o_Car_Y_3    (y3),
    .o_Car_Y_4    (y4),
    .o_Car_Y_5    (y5),
    .o_Move_Strobe(strobe)
  );

  typedef struct packed {
    logic [29:0] xs;
    logic [29:0] ys;
    logic        stb;
  } obs_t;

  obs_t act;
  assign act = {x5, x4, x3, x2, x1, y5, y4, y3, y2, y1, strobe};

  obs_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc_no      = 0;

  int m_tc;
  int m_c [5];
  int m_x [5];

  task automatic model_reset();
    m_tc = 0;
    for (int n = 0; n < 5; n++) begin
      m_c[n] = 0;
      m_x[n] = X0[n];
    end
  endtask

  task automatic model_cycle(output logic stb);
    int p;
    stb = 1'b0;
    if (restart) begin
      model_reset();
    end else if (en && !frz) begin
      if (m_tc == TICK_DIV - 1) begin
        m_tc = 0;
        for (int n = 0; n < 5; n++) begin
          p = PERIOD[n] >> lvl;
          if (p < 1) p = 1;
          m_c[n] = m_c[n] + 1;
          if (m_c[n] >= p) begin
            m_c[n] = 0;
            m_x[n] = (DIR[n] == 1) ? (m_x[n] + 1) % GRID_W : (m_x[n] + GRID_W - 1) % GRID_W;
            stb    = 1'b1;
          end
        end
      end else begin
        m_tc = m_tc + 1;
      end
    end
  endtask

  function automatic logic [29:0] model_xs();
    return {6'(m_x[4]), 6'(m_x[3]), 6'(m_x[2]), 6'(m_x[1]), 6'(m_x[0])};
  endfunction

  task automatic cyc();
    logic stb;
    obs_t e;
    model_cycle(stb);
    q.push_back('{xs: model_xs(), ys: Y_PACK, stb: stb});
    @(posedge clk);
    #1;
    e = q.pop_front();
    cyc_no++;
    vectors++;
    assert (act === e)
    else begin
      miscompares++;
      $error("FAIL cycle_%0d observed=%h expected=%h", cyc_no, act, e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
  endtask

  logic [29:0] snap;

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    frz     = 1'b0;
    restart = 1'b0;
    lvl     = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", {x5, x4, x3, x2, x1}, X0_PACK);
    chk("rst_y", {y5, y4, y3, y2, y1}, Y_PACK);
    chk("rst_stb", strobe, 0);

    rst_n = 1'b1;
    en    = 1'b1;
    model_reset();

    // first move of car 1 lands on tick 12
    repeat (47) cyc();
    chk("t1_x1_before", x1, 12);
    chk("t1_stb_before", strobe, 0);
    cyc();
    chk("t1_x1_step", x1, 11);
    chk("t1_stb", strobe, 1);
    cyc();
    chk("t1_stb_once", strobe, 0);

    // level raised mid-run shrinks periods below live counters
    lvl = 2'd2;
    repeat (20) cyc();
    lvl = 2'd0;
    repeat (13) cyc();

    // freeze holds everything; timing resumes afterwards
    snap = model_xs();
    frz  = 1'b1;
    repeat (100) cyc();
    chk("frz_hold", {x5, x4, x3, x2, x1}, snap);
    frz = 1'b0;
    repeat (60) cyc();

    // level 3: every lane floors to one tick per step
    lvl = 2'd3;
    pulse_restart();
    chk("l3_restart_x", {x5, x4, x3, x2, x1}, X0_PACK);
    repeat (4) cyc();
    chk("l3_x3", x3, 19);
    chk("l3_x5", x5, 29);
    chk("l3_stb", strobe, 1);
    repeat (44) cyc();
    chk("wrap_left_x1_zero", x1, 0);
    chk("wrap_x2_12", x2, 12);
    repeat (4) cyc();
    chk("wrap_left_x1_39", x1, 39);
    repeat (104) cyc();
    chk("wrap_right_x2_39", x2, 39);
    repeat (4) cyc();
    chk("wrap_right_x2_0", x2, 0);
    chk("wrap_x1_back", x1, 12);

    // restart on the same cycle as a step tick
    lvl = 2'd0;
    pulse_restart();
    repeat (15) cyc();
    chk("rs_x3_pre", x3, 20);
    pulse_restart();
    chk("rs_x", {x5, x4, x3, x2, x1}, X0_PACK);
    chk("rs_stb", strobe, 0);
    repeat (15) cyc();
    chk("rs_x3_hold", x3, 20);
    cyc();
    chk("rs_x3_step", x3, 19);
    chk("rs_stb_step", strobe, 1);

    // asynchronous reset between edges
    repeat (40) cyc();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_x", {x5, x4, x3, x2, x1}, X0_PACK);
    chk("arst_stb", strobe, 0);
    chk("arst_y", {y5, y4, y3, y2, y1}, Y_PACK);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (60) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
